// File: rtl/key_filter_multi_if.sv
`default_nettype none
// ============================================================================
//  Module   : key_filter_multi_if
//  Brief    : Key bundle between the board key pins and the debouncer
//             outputs that go to application logic.
//  Revision : 1.0 - initial release
// ============================================================================
interface key_filter_multi_if #(
  parameter int KEY_NUM = 4
);

  logic [KEY_NUM-1:0] key_in;        // raw keys, 0 = pressed
  logic [KEY_NUM-1:0] key_level;     // debounced level, 1 = pressed
  logic [KEY_NUM-1:0] press_flag;    // one-cycle press strobe
  logic [KEY_NUM-1:0] release_flag;  // one-cycle release strobe
  logic [KEY_NUM-1:0] long_flag;     // one-cycle long-press strobe
  logic [KEY_NUM-1:0] repeat_flag;   // one-cycle auto-repeat strobe

  // Board / stimulus side: drives the keys, observes the filtered outputs
  modport master (
    output key_in,
    input  key_level,
    input  press_flag,
    input  release_flag,
    input  long_flag,
    input  repeat_flag
  );

  // Debouncer side
  modport slave (
    input  key_in,
    output key_level,
    output press_flag,
    output release_flag,
    output long_flag,
    output repeat_flag
  );

endinterface
`default_nettype wire

// File: rtl/key_filter_multi.sv
`default_nettype none
// ============================================================================
//  Module   : key_filter_multi
//  Brief    : KEY_NUM independent active-low key debouncers with press,
//             release, long-press and auto-repeat strobes.
//  Revision : 1.0 - initial release
// ============================================================================
module key_filter_multi #(
  parameter int KEY_NUM    = 4,
  parameter int CNT_MAX    = 999_999,
  parameter int LONG_MAX   = 49_999_999,
  parameter int REPEAT_MAX = 4_999_999,
  parameter int REPEAT_EN  = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  key_filter_multi_if.slave bus
);

  localparam int C_DB_W   = $clog2(CNT_MAX + 1);
  localparam int C_LONG_W = $clog2(LONG_MAX + 1);
  localparam int C_REP_W  = $clog2(REPEAT_MAX + 1);

  localparam logic [C_DB_W-1:0]   C_DB_MAX   = C_DB_W'(CNT_MAX);
  localparam logic [C_LONG_W-1:0] C_LONG_MAX = C_LONG_W'(LONG_MAX);
  localparam logic [C_REP_W-1:0]  C_REP_MAX  = C_REP_W'(REPEAT_MAX);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,   // stable released
    S_DB_DN = 2'd1,   // confirming press
    S_DOWN  = 2'd2,   // stable pressed
    S_DB_UP = 2'd3    // confirming release
  } state_t;

  logic [KEY_NUM-1:0] r_sync1;
  logic [KEY_NUM-1:0] r_sync2;
  logic [KEY_NUM-1:0] w_level_vec;
  logic [KEY_NUM-1:0] w_press_vec;
  logic [KEY_NUM-1:0] w_release_vec;
  logic [KEY_NUM-1:0] w_long_vec;
  logic [KEY_NUM-1:0] w_repeat_vec;

  // Two-flop synchroniser; resets to "released" so no false press on exit
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= bus.key_in;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < KEY_NUM; g++) begin : g_ch
    state_t                r_state;
    state_t                w_state_nxt;
    logic [C_DB_W-1:0]     r_db_cnt;
    logic [C_DB_W-1:0]     w_db_nxt;
    logic [C_LONG_W-1:0]   r_long_cnt;
    logic [C_LONG_W-1:0]   w_long_nxt;
    logic [C_REP_W-1:0]    r_rep_cnt;
    logic [C_REP_W-1:0]    w_rep_nxt;
    logic                  r_long_done;
    logic                  w_done_nxt;
    logic                  w_press;
    logic                  w_release;
    logic                  w_long;
    logic                  w_repeat;
    logic                  r_level;
    logic                  r_press;
    logic                  r_release;
    logic                  r_long;
    logic                  r_repeat;
    logic                  w_ks;

    assign w_ks = r_sync2[g];

    // State, counters and registered outputs of this channel
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        r_state     <= S_IDLE;
        r_db_cnt    <= '0;
        r_long_cnt  <= '0;
        r_rep_cnt   <= '0;
        r_long_done <= 1'b0;
        r_level     <= 1'b0;
        r_press     <= 1'b0;
        r_release   <= 1'b0;
        r_long      <= 1'b0;
        r_repeat    <= 1'b0;
      end else begin
        r_state     <= w_state_nxt;
        r_db_cnt    <= w_db_nxt;
        r_long_cnt  <= w_long_nxt;
        r_rep_cnt   <= w_rep_nxt;
        r_long_done <= w_done_nxt;
        r_level     <= (w_state_nxt == S_DOWN) || (w_state_nxt == S_DB_UP);
        r_press     <= w_press;
        r_release   <= w_release;
        r_long      <= w_long;
        r_repeat    <= w_repeat;
      end
    end

    // Next-state, counter updates and strobe decode; counters saturate at max
    always_comb begin
      w_state_nxt = r_state;
      w_db_nxt    = r_db_cnt;
      w_long_nxt  = r_long_cnt;
      w_rep_nxt   = r_rep_cnt;
      w_done_nxt  = r_long_done;
      w_press     = 1'b0;
      w_release   = 1'b0;
      w_long      = 1'b0;
      w_repeat    = 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_ks) begin
            w_state_nxt = S_DB_DN;
            w_db_nxt    = '0;
          end
        end
        S_DB_DN: begin
          if (w_ks) begin
            w_state_nxt = S_IDLE;            // bounce, discard silently
          end else if (r_db_cnt == C_DB_MAX) begin
            w_state_nxt = S_DOWN;
            w_press     = 1'b1;
            w_long_nxt  = '0;
            w_rep_nxt   = '0;
            w_done_nxt  = 1'b0;
          end else begin
            w_db_nxt = r_db_cnt + 1'b1;
          end
        end
        S_DOWN: begin
          if (w_ks) begin
            w_state_nxt = S_DB_UP;
            w_db_nxt    = '0;
          end else if (!r_long_done) begin
            if (r_long_cnt == C_LONG_MAX) begin
              w_long     = 1'b1;
              w_done_nxt = 1'b1;
            end else begin
              w_long_nxt = r_long_cnt + 1'b1;
            end
          end else if (REPEAT_EN != 0) begin
            if (r_rep_cnt == C_REP_MAX) begin
              w_repeat  = 1'b1;
              w_rep_nxt = '0;
            end else begin
              w_rep_nxt = r_rep_cnt + 1'b1;
            end
          end
        end
        S_DB_UP: begin
          // long/repeat progress is frozen here and resumes on a bounce back
          if (!w_ks) begin
            w_state_nxt = S_DOWN;
          end else if (r_db_cnt == C_DB_MAX) begin
            w_state_nxt = S_IDLE;
            w_release   = 1'b1;
          end else begin
            w_db_nxt = r_db_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end

    assign w_level_vec[g]   = r_level;
    assign w_press_vec[g]   = r_press;
    assign w_release_vec[g] = r_release;
    assign w_long_vec[g]    = r_long;
    assign w_repeat_vec[g]  = r_repeat;
  end

  assign bus.key_level    = w_level_vec;
  assign bus.press_flag   = w_press_vec;
  assign bus.release_flag = w_release_vec;
  assign bus.long_flag    = w_long_vec;
  assign bus.repeat_flag  = w_repeat_vec;

endmodule
`default_nettype wire

// File: tb/tb_key_filter_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_filter_multi
//  Brief    : Directed self-checking bench for key_filter_multi with a
//             strobe scoreboard (expected events queued at stimulus time).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_key_filter_multi;

  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_LONG  = 2;
  localparam int K_REP   = 3;

  typedef struct packed {
    int cyc;
    int ch;
    int kind;
  } ev_t;

  logic sys_clk;
  logic sys_rst_n;
  int   cyc;
  int   n_chk;
  int   n_err;
  int   rep0_hits;
  int   long0_hits;
  ev_t  sb[$];
  ev_t  mon_obs;
  ev_t  mon_exp;
  logic [3:0] mon_bits;

  key_filter_multi_if #(.KEY_NUM(2)) bus  ();
  key_filter_multi_if #(.KEY_NUM(2)) bus0 ();

  key_filter_multi #(
    .KEY_NUM(2), .CNT_MAX(3), .LONG_MAX(9), .REPEAT_MAX(4), .REPEAT_EN(1)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  key_filter_multi #(
    .KEY_NUM(2), .CNT_MAX(3), .LONG_MAX(9), .REPEAT_MAX(4), .REPEAT_EN(0)
  ) dut0 (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus0)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000ns");
    $fatal(1);
  end

  // Scoreboard: every strobe seen on the repeat-enabled DUT pops one event
  always @(negedge sys_clk) begin
    for (int ch = 0; ch < 2; ch++) begin
      mon_bits = {bus.repeat_flag[ch], bus.long_flag[ch],
                  bus.release_flag[ch], bus.press_flag[ch]};
      for (int k = 0; k < 4; k++) begin
        if (mon_bits[k]) begin
          mon_obs.cyc  = cyc;
          mon_obs.ch   = ch;
          mon_obs.kind = k;
          if (sb.size() > 0) mon_exp = sb.pop_front();
          else begin
            mon_exp.cyc = -1; mon_exp.ch = -1; mon_exp.kind = -1;
          end
          n_chk++;
          assert (mon_obs === mon_exp) else begin
            n_err++;
            $error("FAIL strobe: observed cyc=%0d ch=%0d kind=%0d expected cyc=%0d ch=%0d kind=%0d",
                   mon_obs.cyc, mon_obs.ch, mon_obs.kind, mon_exp.cyc, mon_exp.ch, mon_exp.kind);
          end
        end
      end
    end
    if (|bus0.repeat_flag) rep0_hits++;
    long0_hits += int'(bus0.long_flag[0]) + int'(bus0.long_flag[1]);
  end

  task automatic push(input int c, input int ch, input int k);
    ev_t e;
    e.cyc = c; e.ch = ch; e.kind = k;
    sb.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input int ch, input logic v);
    bus.key_in[ch]  = v;
    bus0.key_in[ch] = v;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge sys_clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_level"},   32'(bus.key_level),    32'd0);
    chk({tag, "_press"},   32'(bus.press_flag),   32'd0);
    chk({tag, "_release"}, 32'(bus.release_flag), 32'd0);
    chk({tag, "_long"},    32'(bus.long_flag),    32'd0);
    chk({tag, "_repeat"},  32'(bus.repeat_flag),  32'd0);
  endtask

  initial begin
    int t;
    int r;
    n_chk = 0; n_err = 0; rep0_hits = 0; long0_hits = 0;
    sys_rst_n = 1'b0;
    bus.key_in  = 2'b11;
    bus0.key_in = 2'b11;
    repeat (3) @(negedge sys_clk);
    chk_all_zero("reset");
    sys_rst_n = 1'b1;
    repeat (5) @(negedge sys_clk);

    // Clean press and release on channel 0
    t = cyc;
    drive(0, 1'b0);
    push(t + 7, 0, K_PRESS);
    wait_until(t + 6);  chk("s1_level_before", 32'(bus.key_level[0]), 32'd0);
    wait_until(t + 7);  chk("s1_level_at",     32'(bus.key_level[0]), 32'd1);
    chk("s1_ch1_idle", 32'(bus.key_level[1]), 32'd0);
    wait_until(t + 10);
    r = cyc;
    drive(0, 1'b1);
    push(r + 7, 0, K_REL);
    wait_until(r + 6);  chk("s1_rel_before", 32'(bus.key_level[0]), 32'd1);
    wait_until(r + 7);  chk("s1_rel_at",     32'(bus.key_level[0]), 32'd0);
    wait_until(r + 12);

    // Bounce reject: 3-cycle lows separated by 1-cycle highs
    for (int i = 0; i < 5; i++) begin
      drive(0, 1'b0);
      repeat (3) @(negedge sys_clk);
      drive(0, 1'b1);
      @(negedge sys_clk);
    end
    repeat (10) @(negedge sys_clk);
    chk("s2_bounce_level", 32'(bus.key_level[0]), 32'd0);

    // Long press and auto-repeat on channel 1
    t = cyc;
    drive(1, 1'b0);
    push(t + 7,  1, K_PRESS);
    push(t + 17, 1, K_LONG);
    push(t + 22, 1, K_REP);
    push(t + 27, 1, K_REP);
    push(t + 32, 1, K_REP);
    wait_until(t + 33);
    drive(1, 1'b1);
    push(t + 40, 1, K_REL);
    wait_until(t + 36); chk("s3_level_held", 32'(bus.key_level[1]), 32'd1);
    wait_until(t + 55); chk("s3_level_rel",  32'(bus.key_level[1]), 32'd0);

    // Release bounce on channel 0 delays long_flag by the DB_UP cycles
    t = cyc;
    drive(0, 1'b0);
    push(t + 7,  0, K_PRESS);
    push(t + 20, 0, K_LONG);
    wait_until(t + 9);
    drive(0, 1'b1);
    wait_until(t + 11);
    drive(0, 1'b0);
    wait_until(t + 13); chk("s4_level_bounce", 32'(bus.key_level[0]), 32'd1);
    wait_until(t + 16); chk("s4_level_back",   32'(bus.key_level[0]), 32'd1);
    wait_until(t + 21);
    drive(0, 1'b1);
    push(t + 28, 0, K_REL);
    wait_until(t + 35);

    // Both channels together
    t = cyc;
    drive(0, 1'b0);
    drive(1, 1'b0);
    push(t + 7,  0, K_PRESS); push(t + 7,  1, K_PRESS);
    push(t + 17, 0, K_LONG);  push(t + 17, 1, K_LONG);
    push(t + 22, 0, K_REP);   push(t + 22, 1, K_REP);
    push(t + 27, 0, K_REP);   push(t + 27, 1, K_REP);
    wait_until(t + 7);  chk("s5_level_both", 32'(bus.key_level), 32'd3);
    wait_until(t + 28);
    drive(0, 1'b1);
    drive(1, 1'b1);
    push(t + 35, 0, K_REL);   push(t + 35, 1, K_REL);
    wait_until(t + 45);

    // Asynchronous reset while a key is held after its long press
    t = cyc;
    drive(0, 1'b0);
    push(t + 7,  0, K_PRESS);
    push(t + 17, 0, K_LONG);
    wait_until(t + 19);
    chk("s6_level_pre", 32'(bus.key_level[0]), 32'd1);
    #2 sys_rst_n = 1'b0;
    #1 chk_all_zero("s6_rst");
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    r = cyc;
    push(r + 7, 0, K_PRESS);
    wait_until(r + 6);  chk("s6_level_before", 32'(bus.key_level[0]), 32'd0);
    wait_until(r + 9);
    drive(0, 1'b1);
    push(r + 16, 0, K_REL);
    wait_until(r + 25);

    chk("sb_empty",        32'(sb.size()),  32'd0);
    chk("noreq_repeat",    32'(rep0_hits),  32'd0);
    chk("noreq_long_hits", 32'(long0_hits), 32'd5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/key_filter_multi.md
# key_filter_multi

Parametrised multi-channel key debouncer, the successor to the single-key 20 ms filter. Each of `KEY_NUM` active-low mechanical key inputs is synchronised and debounced independently. Per channel the block produces a stable key level, one-cycle press and release strobes, a long-press strobe and optional auto-repeat strobes. It sits between board key pins and application control logic (LED, counter and menu FSMs) in the 50 MHz `sys_clk` domain.

## Interface
Parameters:
- `KEY_NUM`, default 4: number of independent key channels (≥1).
- `CNT_MAX`, default 999_999: debounce count, 20 ms at 50 MHz (≥1).
- `LONG_MAX`, default 49_999_999: long-press count, 1 s (≥1).
- `REPEAT_MAX`, default 4_999_999: auto-repeat interval count, 100 ms (≥1).
- `REPEAT_EN`, default 1: 1 = generate repeat strobes after a long press; 0 = never assert `repeat_flag`.

Counter widths are derived internally as `$clog2(X+1)` of each count parameter.

Ports:
- `sys_clk` in 1: system clock.
- `sys_rst_n` in 1: reset, asynchronous, active-low.
- `key_in` in `KEY_NUM`: raw keys, asynchronous, 0 = pressed.
- `key_level` out `KEY_NUM`: debounced state, 1 = pressed.
- `press_flag` out `KEY_NUM`: one-cycle strobe when a press is confirmed.
- `release_flag` out `KEY_NUM`: one-cycle strobe when a release is confirmed.
- `long_flag` out `KEY_NUM`: one-cycle strobe once per press at the long-press threshold.
- `repeat_flag` out `KEY_NUM`: one-cycle strobe every `REPEAT_MAX+1` cycles after `long_flag` while the key is held.

## Operation
- Each channel is an identical, fully independent slice; there is no cross-channel interaction.
- Synchroniser: 2 flip-flops per channel, both reset to 1 (released). All logic uses the synchronised value `ks`.
- Per-channel FSM states: `IDLE` (stable released), `DB_DN` (confirming press), `DOWN` (stable pressed), `DB_UP` (confirming release).
- `IDLE`: on `ks==0` go to `DB_DN` with `db_cnt=0`.
- `DB_DN`:
  - `ks==1` → back to `IDLE`; this is a bounce, no flag.
  - Else, if `db_cnt==CNT_MAX` → `DOWN`, pulse `press_flag`, clear `long_cnt` and `rep_cnt`, clear the `long_done` bit.
  - Else `db_cnt+1`.
- `DOWN`:
  - `ks==1` → `DB_UP` with `db_cnt=0`.
  - Else, if `long_done==0`: when `long_cnt==LONG_MAX`, pulse `long_flag` and set `long_done`; otherwise `long_cnt+1`.
  - Else, if `REPEAT_EN`: when `rep_cnt==REPEAT_MAX`, pulse `repeat_flag` and set `rep_cnt=0`; otherwise `rep_cnt+1`.
- `DB_UP`:
  - `ks==0` → back to `DOWN`, no flag. `long_cnt`, `rep_cnt` and `long_done` hold their values during `DB_UP` and resume on return.
  - Else, if `db_cnt==CNT_MAX` → `IDLE`, pulse `release_flag`.
  - Else `db_cnt+1`.
- `key_level` is 1 in `DOWN` and `DB_UP`, and 0 in `IDLE` and `DB_DN`.
- Counters never wrap: each is compared against its maximum and cleared or stopped at that value.
- `long_flag` fires at most once per confirmed press.

## Timing
- All outputs are registered. Reset value: every output bit 0, FSM in `IDLE`, all counters 0.
- Press latency: with `key_in` stable 0 from clock edge E0, `press_flag` is high exactly at E0+`CNT_MAX`+4 (2 synchroniser + 1 `IDLE` exit + `CNT_MAX`+1 count), for one cycle. `key_level` rises at the same edge.
- Release latency is symmetric: `release_flag` and the `key_level` fall occur at E0+`CNT_MAX`+4 after `key_in` goes stable 1.
- `long_flag` rises `LONG_MAX`+1 cycles after `press_flag`, excluding any cycles spent in `DB_UP`.
- The first `repeat_flag` rises `REPEAT_MAX`+1 cycles after `long_flag`; subsequent strobes follow every `REPEAT_MAX`+1 cycles.
- A glitch shorter than `CNT_MAX`+1 synchronised cycles produces no flag and no `key_level` change.
- `release_flag` and `press_flag` of one channel are never high in the same cycle. Different channels may strobe in the same cycle.
- Asynchronous reset mid-operation: outputs clear immediately. After reset release, a key that is still held is treated as a new press and produces a full press latency.

## Test plan
Test parameters: `KEY_NUM`=2, `CNT_MAX`=3, `LONG_MAX`=9, `REPEAT_MAX`=4, `REPEAT_EN`=1.
- Clean press: `key_in[0]` driven 0 at E0 and held → `press_flag[0]` single pulse at E7, `key_level[0]`=1 from E7. No flags on channel 1.
- Bounce reject: `key_in[0]` pulses 0 for 3 cycles, repeated 5 times with 1-cycle highs → no `press_flag`, `key_level[0]` stays 0.
- Long and repeat: hold `key_in[1]` 0 → `press_flag[1]` at E7, `long_flag[1]` at E17, `repeat_flag[1]` at E22, E27, E32. Release → `release_flag[1]` 7 cycles after the edge and no further repeats.
- Release bounce: while in `DOWN`, drive `key_in[0]` 1 for 2 cycles then 0 → no `release_flag`, `key_level[0]` stays 1, `long_flag` delayed by the cycles spent in `DB_UP`.
- Simultaneous channels: both keys pressed at the same edge → both `press_flag` bits pulse at E7 in the same cycle. With `REPEAT_EN`=0, `repeat_flag` stays 0 throughout.
- Reset mid-hold: assert `sys_rst_n`=0 after `long_flag` with the key still held → all outputs 0 immediately. Release reset → `press_flag` again 7 cycles later.
